uart_to_sdram: RTL and testbench
================================

Name: uart_to_sdram

Overview:
Command parser on the receive side of the UART debug link. It accepts bytes from the UART receiver over a strobe/ack handshake and assembles read or write frames. Each completed frame becomes one read or write request to the SDRAM controller. Read data and write acknowledgements return to the host through the existing SDRAM-to-UART transmit path.

Parameters:
ADDR_BYTES, 3, number of address bytes per frame, sent MSB first; address width is 8*ADDR_BYTES.
TIMEOUT_CYC, 1000000, maximum CLK cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST_N  input  1  asynchronous, active-low reset.
i_data  input  8  byte from UART receiver.
i_stb  input  1  i_data valid; held until i_ack.
i_ack  output  1  byte accepted this cycle (combinational).
o_addr  output  8*ADDR_BYTES  SDRAM word address.
o_data  output  16  SDRAM write data.
o_stb_rd  output  1  read request; held until o_ack.
o_stb_wt  output  1  write request; held until o_ack.
o_ack  input  1  SDRAM controller accepted request.
o_err  output  1  one-cycle pulse on frame abort (bad command or timeout).

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; o_addr=0, o_data=0, o_stb_rd=0, o_stb_wt=0, o_err=0; byte and timeout counters=0. i_ack=0 while RST_N is low.
- Byte transfer: occurs on a cycle with i_stb & i_ack.
  - i_ack = i_stb & (state is IDLE, ADDR or DATA).
  - i_ack=0 in ISSUE, so upstream holds its byte.
- Frame format:
  - Command byte: 0x52 'R' or 0x57 'W'.
  - Then ADDR_BYTES address bytes, MSB first.
  - For 'W' only, then 2 data bytes, MSB first (first byte goes to o_data[15:8]).
- States and transitions:
  - IDLE:
    - 'R' or 'W' accepted: latch the op, clear o_addr, -> ADDR.
    - Any other byte is accepted and dropped, o_err pulses 1 cycle, stay IDLE.
  - ADDR:
    - Each accepted byte does o_addr <= {o_addr[8*ADDR_BYTES-9:0], i_data}.
    - After the ADDR_BYTES-th byte: -> ISSUE if op is read, -> DATA if op is write.
  - DATA:
    - First byte loads o_data[15:8]; second byte loads o_data[7:0], -> ISSUE.
  - ISSUE:
    - o_stb_rd (read) or o_stb_wt (write) is asserted, registered, from the first ISSUE cycle.
    - The strobe stays high until a cycle with o_ack=1.
    - That cycle is the last strobe cycle; the next cycle is state=IDLE with the strobe at 0.
- Strobes are never both high. o_addr and o_data are stable for the whole ISSUE period and hold their values after it.
- Latency: strobe rises on the cycle after the last frame byte is accepted.
- Timeout:
  - Counter runs in ADDR and DATA only; it clears on every accepted byte and on entering ADDR.
  - If it reaches TIMEOUT_CYC-1 with no byte: -> IDLE, o_err pulses 1 cycle, no request is issued.
  - ISSUE has no timeout and waits indefinitely for o_ack.
- o_ack outside ISSUE is ignored.
- A byte valid with i_stb in the same cycle as the timeout expiry is not accepted (i_ack=0 that cycle); the abort wins.
- Reset mid-frame or mid-ISSUE: strobes drop immediately; the partial frame is discarded.

Decomposition:
- Shared package (sdram_uart_pkg) holds:
  - command constants CMD_RD=8'h52, CMD_WT=8'h57;
  - state encoding IDLE/ADDR/DATA/ISSUE;
  - reply constants 8'h4F/8'h4B used by the transmit side.
- Optional sub-module uart_to_sdram_timer: loadable timeout counter with clear/enable inputs and an expiry output.
- The FSM and shift registers stay in the top module.

Test Plan:
- Read frame 52 01 23 45, o_ack 3 cycles after strobe rises -> o_stb_rd high for exactly 4 cycles, o_addr=24'h012345, o_stb_wt=0, o_err never pulses.
- Write frame 57 00 00 10 BE EF, o_ack immediate -> o_stb_wt high 1 cycle, o_addr=24'h000010, o_data=16'hBEEF.
- Garbage byte 0x41 then read frame 52 00 00 01 -> o_err 1-cycle pulse, then a normal read at address 1.
- Frame 57 00 then silence, TIMEOUT_CYC=16 -> o_err pulse; no strobe; a following frame 52 00 00 02 reads address 2.
- Byte offered with i_stb while in ISSUE -> i_ack=0 until the o_ack cycle has passed; the byte is accepted in IDLE as the next command.
- RST_N low while o_stb_wt is high -> strobe drops asynchronously; o_addr=0 and o_data=0; after release the next frame works.

Source files
------------

// File: rtl/sdram_uart_pkg.sv
// -----------------------------------------------------------------------------
// sdram_uart_pkg
// Definitions shared by both directions of the UART debug link to SDRAM:
//   - host command bytes ('R' read, 'W' write)
//   - command-parser state encoding
//   - reply bytes used by the SDRAM-to-UART transmit side
// -----------------------------------------------------------------------------
package sdram_uart_pkg;

  localparam logic [7:0] CMD_RD = 8'h52;  // 'R'
  localparam logic [7:0] CMD_WT = 8'h57;  // 'W'

  localparam logic [7:0] RSP_O  = 8'h4F;  // 'O'
  localparam logic [7:0] RSP_K  = 8'h4B;  // 'K'

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

  // True when the byte opens a frame.
  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_RD) || (b == CMD_WT);
  endfunction

endpackage

// File: rtl/uart_to_sdram_timer.sv
// -----------------------------------------------------------------------------
// uart_to_sdram_timer
// Inter-byte timeout counter for the command parser.
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   i_clr       restart the count (a byte was accepted)
//   i_en        count while a frame is being collected; held at 0 otherwise
//   o_expire    count has reached TIMEOUT_CYC-1 while enabled (combinational)
// -----------------------------------------------------------------------------
module uart_to_sdram_timer #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_en && (r_cnt == CW'(TIMEOUT_CYC - 1));

  // Disabled or expired counts restart from zero so the next frame
  // always gets the full window.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_to_sdram.sv
// -----------------------------------------------------------------------------
// uart_to_sdram
// Receive-side command parser of the UART debug link. Bytes from the UART
// receiver are assembled into frames:
//   'R' addr[ADDR_BYTES]            -> one SDRAM read request
//   'W' addr[ADDR_BYTES] d_hi d_lo  -> one SDRAM write request
// Address and data are sent MSB first.
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   i_data       byte from UART receiver
//   i_stb        i_data valid, held until i_ack
//   i_ack        byte accepted this cycle (combinational)
//   o_addr       SDRAM word address
//   o_data       SDRAM write data
//   o_stb_rd     read request, held until o_ack
//   o_stb_wt     write request, held until o_ack
//   o_ack        SDRAM controller accepted the request
//   o_err        one-cycle pulse when a frame is aborted
// -----------------------------------------------------------------------------
module uart_to_sdram
  import sdram_uart_pkg::*;
#(
  parameter int ADDR_BYTES  = 3,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [7:0]              i_data,
  input  logic                    i_stb,
  output logic                    i_ack,
  output logic [8*ADDR_BYTES-1:0] o_addr,
  output logic [15:0]             o_data,
  output logic                    o_stb_rd,
  output logic                    o_stb_wt,
  input  logic                    o_ack,
  output logic                    o_err
);

  localparam int AW  = 8 * ADDR_BYTES;
  localparam int BCW = $clog2(ADDR_BYTES + 1);

  state_t           r_state;
  logic             r_is_wt;
  logic [BCW-1:0]   r_bcnt;
  logic [AW-1:0]    r_addr;
  logic [15:0]      r_data;
  logic             r_stb_rd;
  logic             r_stb_wt;
  logic             r_err;

  logic             w_open;
  logic             w_take;
  logic             w_expire;
  logic             w_timer_en;

  assign w_open     = (r_state == ST_IDLE) || (r_state == ST_ADDR) ||
                      (r_state == ST_DATA);
  assign w_timer_en = (r_state == ST_ADDR) || (r_state == ST_DATA);
  // An expiring timeout takes priority over a byte arriving the same cycle;
  // RST_N gates i_ack so nothing is acknowledged while in reset.
  assign w_take     = i_stb && w_open && !w_expire && RST_N;
  assign i_ack      = w_take;

  assign o_addr   = r_addr;
  assign o_data   = r_data;
  assign o_stb_rd = r_stb_rd;
  assign o_stb_wt = r_stb_wt;
  assign o_err    = r_err;

  uart_to_sdram_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .i_clr    (w_take),
    .i_en     (w_timer_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ST_IDLE;
      r_is_wt  <= 1'b0;
      r_bcnt   <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_stb_rd <= 1'b0;
      r_stb_wt <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            if (is_cmd(i_data)) begin
              r_is_wt <= (i_data == CMD_WT);
              r_addr  <= '0;
              r_bcnt  <= '0;
              r_state <= ST_ADDR;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        ST_ADDR: begin
          if (w_expire) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_take) begin
            r_addr <= {r_addr[AW-9:0], i_data};
            if (r_bcnt == BCW'(ADDR_BYTES - 1)) begin
              r_bcnt <= '0;
              if (r_is_wt) begin
                r_state <= ST_DATA;
              end else begin
                r_stb_rd <= 1'b1;
                r_state  <= ST_ISSUE;
              end
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (w_expire) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_take) begin
            if (r_bcnt == '0) begin
              r_data[15:8] <= i_data;
              r_bcnt       <= r_bcnt + 1'b1;
            end else begin
              r_data[7:0] <= i_data;
              r_bcnt      <= '0;
              r_stb_wt    <= 1'b1;
              r_state     <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          // No timeout here: the controller may stall as long as it likes.
          if (o_ack) begin
            r_stb_rd <= 1'b0;
            r_stb_wt <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_to_sdram.sv
// -----------------------------------------------------------------------------
// tb_uart_to_sdram
// Directed and randomized frames sent through the parser; expected requests
// are derived from the frame contents (address/data values, command byte) and
// the number of abort events the bench itself provokes.
// -----------------------------------------------------------------------------
module tb_uart_to_sdram;

  localparam int ADDR_BYTES  = 3;
  localparam int TIMEOUT_CYC = 16;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  i_data;
  logic        i_stb;
  logic        i_ack;
  logic [23:0] o_addr;
  logic [15:0] o_data;
  logic        o_stb_rd;
  logic        o_stb_wt;
  logic        o_ack;
  logic        o_err;

  int checks  = 0;
  int errors  = 0;
  int exp_err = 0;

  // Observed-event counters, written only by the monitor below.
  int  err_seen = 0;
  int  err_long = 0;
  int  both_hi  = 0;
  int  stb_cyc  = 0;
  logic prev_err = 1'b0;

  uart_to_sdram #(
    .ADDR_BYTES  (ADDR_BYTES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .i_data   (i_data),
    .i_stb    (i_stb),
    .i_ack    (i_ack),
    .o_addr   (o_addr),
    .o_data   (o_data),
    .o_stb_rd (o_stb_rd),
    .o_stb_wt (o_stb_wt),
    .o_ack    (o_ack),
    .o_err    (o_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (o_err) err_seen++;
    if (o_err && prev_err) err_long++;
    prev_err = o_err;
    if (o_stb_rd && o_stb_wt) both_hi++;
    if (o_stb_rd || o_stb_wt) stb_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one byte after 'gap' idle cycles and hold it until accepted.
  // Returns at posedge+1 of the accepting edge with i_stb released.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) @(posedge CLK);
    @(negedge CLK);
    i_data = b;
    i_stb  = 1'b1;
    #1;
    while (!i_ack && n < 60) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("byte_ack", i_ack, 1'b1);
    @(posedge CLK);
    #1;
    i_stb = 1'b0;
  endtask

  task automatic send_frame(input bit wt, input logic [23:0] a, input logic [15:0] d,
                            input int gap);
    send_byte(wt ? 8'h57 : 8'h52, 0);
    for (int i = 0; i < ADDR_BYTES; i++)
      send_byte(8'((a >> (8 * (ADDR_BYTES - 1 - i))) & 24'hFF), gap);
    if (wt) begin
      send_byte(d / 256, gap);
      send_byte(d % 256, gap);
    end
  endtask

  // Called right after the last frame byte is accepted: the request must
  // already be up, last exactly delay+1 cycles, and keep addr/data steady.
  task automatic issue_chk(input string tag, input bit wt, input logic [23:0] a,
                           input logic [15:0] d, input int delay);
    int hi;
    bit unstable;
    hi = 0;
    unstable = 0;
    chk({tag, "_rd"}, o_stb_rd, !wt);
    chk({tag, "_wt"}, o_stb_wt, wt);
    chk({tag, "_addr"}, o_addr, a);
    if (wt) chk({tag, "_data"}, o_data, d);
    for (int k = 0; k <= delay + 3; k++) begin
      @(negedge CLK);
      if (o_stb_rd || o_stb_wt) hi++;
      if (o_addr !== a || (wt && o_data !== d)) unstable = 1'b1;
      o_ack = (k == delay);
    end
    chk({tag, "_len"}, hi, delay + 1);
    chk({tag, "_stable"}, unstable, 1'b0);
    chk({tag, "_done"}, {o_stb_rd, o_stb_wt}, 2'b00);
  endtask

  initial begin
    int s0;
    bit          wt;
    logic [23:0] a;
    logic [15:0] d;
    logic [7:0]  g;

    // Reset state, with a byte already offered.
    RST_N  = 1'b0;
    i_stb  = 1'b1;
    i_data = 8'h52;
    o_ack  = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_iack", i_ack, 1'b0);
    chk("rst_stb", {o_stb_rd, o_stb_wt}, 2'b00);
    chk("rst_err", o_err, 1'b0);
    chk("rst_addr", o_addr, 24'h0);
    chk("rst_data", o_data, 16'h0);
    i_stb = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;

    // Read with delayed acknowledge.
    send_frame(1'b0, 24'h012345, 16'h0, 0);
    issue_chk("rd1", 1'b0, 24'h012345, 16'h0, 3);

    // Write with immediate acknowledge.
    send_frame(1'b1, 24'h000010, 16'hBEEF, 0);
    issue_chk("wt1", 1'b1, 24'h000010, 16'hBEEF, 0);
    chk("wt1_hold_data", o_data, 16'hBEEF);

    // Garbage byte then a normal read.
    send_byte(8'h41, 0);
    exp_err++;
    chk("garb_err_hi", o_err, 1'b1);
    @(posedge CLK);
    #1;
    chk("garb_err_lo", o_err, 1'b0);
    send_frame(1'b0, 24'h000001, 16'h0, 0);
    issue_chk("rd_after_garb", 1'b0, 24'h000001, 16'h0, 1);

    // Longest gap that still keeps the frame alive.
    send_frame(1'b1, 24'hABCDEF, 16'h1234, TIMEOUT_CYC - 2);
    issue_chk("gap_max", 1'b1, 24'hABCDEF, 16'h1234, 2);

    // Timeout: a byte offered on the expiry cycle is refused, frame aborts.
    s0 = stb_cyc;
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    repeat (TIMEOUT_CYC - 1) @(posedge CLK);
    @(negedge CLK);
    i_data = 8'h11;
    i_stb  = 1'b1;
    #1;
    chk("to_refused", i_ack, 1'b0);
    @(posedge CLK);
    #1;
    i_stb = 1'b0;
    exp_err++;
    chk("to_err", o_err, 1'b1);
    repeat (4) @(posedge CLK);
    #1;
    chk("to_no_stb", stb_cyc, s0);
    send_frame(1'b0, 24'h000002, 16'h0, 0);
    issue_chk("rd_after_to", 1'b0, 24'h000002, 16'h0, 0);

    // Byte offered during ISSUE is held off until the request completes.
    send_frame(1'b0, 24'h000007, 16'h0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        i_data = 8'h52;
        i_stb  = 1'b1;
      end
      o_ack = (k == 3);
      #1;
      chk("issue_hold_iack", i_ack, 1'b0);
      chk("issue_hold_stb", o_stb_rd, 1'b1);
    end
    @(negedge CLK);
    o_ack = 1'b0;
    #1;
    chk("idle_iack", i_ack, 1'b1);
    @(posedge CLK);
    #1;
    i_stb = 1'b0;
    for (int i = 0; i < ADDR_BYTES; i++) send_byte((i == 2) ? 8'h09 : 8'h00, 0);
    issue_chk("held_cmd_rd", 1'b0, 24'h000009, 16'h0, 1);

    // Reset while a write is outstanding.
    send_frame(1'b1, 24'h123456, 16'hA5A5, 0);
    chk("pre_rst_wt", o_stb_wt, 1'b1);
    @(negedge CLK);
    i_stb = 1'b1;
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_wt", o_stb_wt, 1'b0);
    chk("arst_addr", o_addr, 24'h0);
    chk("arst_data", o_data, 16'h0);
    chk("arst_iack", i_ack, 1'b0);
    i_stb = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    send_frame(1'b0, 24'h000003, 16'h0, 0);
    issue_chk("rd_after_rst", 1'b0, 24'h000003, 16'h0, 2);

    // Randomized frames, some preceded by a non-command byte.
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'h52 || g == 8'h57) g = 8'h00;
        send_byte(g, $urandom_range(0, 3));
        exp_err++;
      end
      wt = 1'($urandom_range(0, 1));
      a  = 24'($urandom);
      d  = 16'($urandom);
      send_frame(wt, a, d, $urandom_range(0, TIMEOUT_CYC - 4));
      issue_chk("rand", wt, a, d, $urandom_range(0, 5));
    end

    repeat (2) @(posedge CLK);
    #1;
    chk("err_count", err_seen, exp_err);
    chk("err_one_cycle", err_long, 0);
    chk("never_both", both_hi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
